// File: rtl/pwm_update_scheduler.sv
// Serialises PWM configuration updates from N requesters onto the single
// d/sel write port of the PWM. Updates land either glitch-free on the period
// boundary (cmp on the wrap edge, top right after) or immediately followed
// by a counter restart.
module pwm_update_scheduler #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    input  logic [16*N-1:0]   req_top,
    input  logic [16*N-1:0]   req_cmp,
    input  logic [N-1:0]      req_sync,
    output logic [N-1:0]      req_ready,
    input  logic [15:0]       pwm_cnt,
    input  logic [15:0]       pwm_top,
    output logic [15:0]       pwm_d,
    output logic [1:0]        pwm_sel,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, WAIT_BND, WR_TOP, NOW_CMP, NOW_TOP, NOW_CNT
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    logic           xfer;
    logic           bnd;
    logic [15:0]    pick_top, pick_cmp;
    logic           pick_sync;
    logic [15:0]    sh_top, sh_cmp;
    int             j;

    // Last cycle of the current PWM period: the PWM wraps cnt on the next edge.
    assign bnd  = (pwm_cnt >= pwm_top);
    assign busy = (state != IDLE);
    assign xfer = (state == IDLE) && found;

    // Round-robin search starting at rr, plus a mux of the winner's payload.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        idx       = '0;
        j         = 0;
        pick_top  = '0;
        pick_cmp  = '0;
        pick_sync = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr) + k;
            if (j >= N) j = j - N;
            idx = IDW'(j);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pick == IDW'(i)) begin
                pick_top  = req_top[16*i +: 16];
                pick_cmp  = req_cmp[16*i +: 16];
                pick_sync = req_sync[i];
            end
        end
    end

    // One-hot ready toward the winner, only while idle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++)
            req_ready[i] = xfer && (pick == IDW'(i));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Shadow registers, grant index and round-robin pointer update on accept.
    // The sync flag is not shadowed: it is captured by the path the FSM takes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_top   <= '0;
            sh_cmp   <= '0;
            grant_id <= '0;
            rr       <= '0;
        end else if (xfer) begin
            sh_top   <= pick_top;
            sh_cmp   <= pick_cmp;
            grant_id <= pick;
            rr       <= (pick == IDW'(N-1)) ? '0 : pick + 1'b1;
        end
    end

    // Next state and PWM write decode; d is forced to 0 whenever sel is 00.
    always_comb begin
        state_nxt = state;
        pwm_sel   = 2'b00;
        pwm_d     = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = pick_sync ? WAIT_BND : NOW_CMP;
            end
            WAIT_BND: begin
                if (bnd) begin
                    pwm_sel   = 2'b01;
                    pwm_d     = sh_cmp;
                    state_nxt = WR_TOP;
                end
            end
            WR_TOP: begin
                pwm_sel   = 2'b10;
                pwm_d     = sh_top;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            NOW_CMP: begin
                pwm_sel   = 2'b01;
                pwm_d     = sh_cmp;
                state_nxt = NOW_TOP;
            end
            NOW_TOP: begin
                pwm_sel   = 2'b10;
                pwm_d     = sh_top;
                state_nxt = NOW_CNT;
            end
            NOW_CNT: begin
                pwm_sel   = 2'b11;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Bench for pwm_update_scheduler: a small PWM plant closes the cnt/top loop,
// a transaction-level model predicts grants and handshake timing, and a
// scoreboard matches each completed update's write burst against the model.
module tb_pwm_update_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n, prst_n;
    logic [N-1:0]      req_valid, req_sync, req_ready;
    logic [16*N-1:0]   req_top, req_cmp;
    logic [15:0]       pwm_cnt, pwm_top, pwm_cmp, pwm_d;
    logic [1:0]        pwm_sel;
    logic              busy, done;
    logic [IDW-1:0]    grant_id;

    always #5 clk = ~clk;

    pwm_update_scheduler #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_top(req_top), .req_cmp(req_cmp),
        .req_sync(req_sync), .req_ready(req_ready),
        .pwm_cnt(pwm_cnt), .pwm_top(pwm_top),
        .pwm_d(pwm_d), .pwm_sel(pwm_sel),
        .busy(busy), .grant_id(grant_id), .done(done)
    );

    // PWM plant: counts 0..top, wraps, accepts cmp/top/cnt writes.
    always @(posedge clk or negedge prst_n) begin
        if (!prst_n) begin
            pwm_cnt <= 16'd0;
            pwm_top <= 16'd9;
            pwm_cmp <= 16'd0;
        end else begin
            if (pwm_sel == 2'b11)          pwm_cnt <= pwm_d;
            else if (pwm_cnt >= pwm_top)   pwm_cnt <= 16'd0;
            else                           pwm_cnt <= pwm_cnt + 16'd1;
            if (pwm_sel == 2'b01) pwm_cmp <= pwm_d;
            if (pwm_sel == 2'b10) pwm_top <= pwm_d;
        end
    end

    typedef struct { int id; int top; int cmp; bit sync; } upd_t;
    upd_t exp_q[$];
    int   gq[$];
    int   ncmp = 0;
    int   nfail = 0;
    logic [N-1:0] hs_q = '0;

    task automatic chk(input string nm, input longint act, input longint expv);
        ncmp++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: one update in flight; immediate updates occupy 3 cycles
    // after accept, sync updates wait for the first later boundary, then 1 more.
    initial begin : model
        int m_state, m_left, m_rr, w, jj;
        bit found, m_bnd;
        logic [N-1:0] exp_rdy;
        upd_t e;
        m_state = 0; m_left = 0; m_rr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_sel", pwm_sel, 0);
                chk("rst_d", pwm_d, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                m_state = 0; m_left = 0; m_rr = 0;
                exp_q.delete();
                hs_q = '0;
            end else begin
                m_bnd   = (pwm_cnt >= pwm_top);
                found   = 0;
                w       = 0;
                exp_rdy = '0;
                if (m_state == 0) begin
                    for (int k = 0; k < N; k++) begin
                        jj = (m_rr + k) % N;
                        if (!found && req_valid[jj]) begin found = 1; w = jj; end
                    end
                end
                if (found) exp_rdy[w] = 1'b1;
                chk("req_ready", req_ready, exp_rdy);
                chk("busy", busy, m_state != 0);
                chk("done", done, (m_state == 2) && (m_left == 1));
                hs_q = req_valid & req_ready;
                for (int i = 0; i < N; i++) if (hs_q[i]) gq.push_back(i);
                case (m_state)
                    0: if (found) begin
                        e.id   = w;
                        e.top  = int'(req_top[16*w +: 16]);
                        e.cmp  = int'(req_cmp[16*w +: 16]);
                        e.sync = req_sync[w];
                        exp_q.push_back(e);
                        m_rr = (w + 1) % N;
                        if (e.sync) m_state = 1;
                        else begin m_state = 2; m_left = 3; end
                    end
                    1: if (m_bnd) begin m_state = 2; m_left = 1; end
                    default: begin
                        m_left--;
                        if (m_left == 0) m_state = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor: collect writes, compare the burst when done pulses.
    initial begin : monitor
        int wsel[$], wd[$], wcnt[$];
        bit wbnd[$];
        upd_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wsel.delete(); wd.delete(); wcnt.delete(); wbnd.delete();
            end else begin
                if (pwm_sel == 2'b00) chk("idle_d", pwm_d, 0);
                else begin
                    wsel.push_back(int'(pwm_sel));
                    wd.push_back(int'(pwm_d));
                    wcnt.push_back(int'(pwm_cnt));
                    wbnd.push_back(pwm_cnt >= pwm_top);
                end
                if (done) begin
                    chk("exp_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("grant_id", grant_id, e.id);
                        chk("n_writes", wsel.size(), e.sync ? 2 : 3);
                        if (wsel.size() == (e.sync ? 2 : 3)) begin
                            chk("w0_sel", wsel[0], 1);
                            chk("w0_cmp", wd[0], e.cmp);
                            chk("w1_sel", wsel[1], 2);
                            chk("w1_top", wd[1], e.top);
                            if (e.sync) begin
                                chk("cmp_at_bnd", wbnd[0], 1);
                                chk("top_at_cnt0", wcnt[1], 0);
                            end else begin
                                chk("w2_sel", wsel[2], 3);
                                chk("w2_d", wd[2], 0);
                            end
                        end
                    end
                    wsel.delete(); wd.delete(); wcnt.delete(); wbnd.delete();
                end
            end
        end
    end

    // mode 0: release all; 1: all held valid, immediate; 2: random traffic.
    task automatic drive(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) req_valid[i] = 1'b0;
            else if (mode == 1) begin
                if (hs_q[i]) begin
                    req_top[16*i +: 16] = 16'($urandom_range(0, 12));
                    req_cmp[16*i +: 16] = 16'($urandom_range(0, 13));
                end
                req_valid[i] = 1'b1;
                req_sync[i]  = 1'b0;
            end else begin
                if (hs_q[i] || (req_valid[i] && $urandom_range(0, 19) == 0))
                    req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_top[16*i +: 16] = 16'($urandom_range(0, 12));
                    req_cmp[16*i +: 16] = 16'($urandom_range(0, 13));
                    req_sync[i] = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        drive(0);
        t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_idle", busy, 0);
    endtask

    initial begin : stim
        int t;
        rst_n = 1'b0; prst_n = 1'b0;
        req_valid = '1; req_sync = '0;
        req_top = {16'd7, 16'd6, 16'd5, 16'd4};
        req_cmp = {16'd3, 16'd2, 16'd1, 16'd0};
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        prst_n = 1'b1; rst_n = 1'b1;
        #1 chk("ready_after_rst", req_ready, 1);

        // All requesters held valid: strict rotation.
        repeat (24) begin @(posedge clk); #1; drive(1); end
        chk("gq_len", gq.size() >= 5, 1);
        if (gq.size() >= 5) begin
            chk("grant0", gq[0], 0); chk("grant1", gq[1], 1);
            chk("grant2", gq[2], 2); chk("grant3", gq[3], 3);
            chk("grant4", gq[4], 0);
        end
        drain();

        // Randomised mix of sync/immediate updates, drops and contention.
        repeat (4000) begin @(posedge clk); #1; drive(2); end
        drain();
        chk("queue_empty", exp_q.size(), 0);

        // Reset while waiting for the boundary aborts the update.
        req_top[15:0] = 16'd8; req_cmp[15:0] = 16'd3;
        req_sync = 4'b0001; req_valid = 4'b0001;
        t = 0;
        while (!busy && t < 20) begin @(posedge clk); #1; t++; end
        chk("mid_busy", busy, 1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", pwm_sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '1; req_sync = '0;
        rst_n = 1'b1;
        #1 chk("rr_after_rst", req_ready, 1);
        repeat (12) begin @(posedge clk); #1; drive(1); end
        drain();
        chk("queue_empty_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
